// File: rtl/ll_sc_link_unit.sv
// Load-link / store-conditional reservation monitor in the EX stage.
// Tracks one word reservation and resolves each SC in the cycle it occupies EX.
module ll_sc_link_unit #(
  parameter int BITS         = 32,
  parameter int LINK_TIMEOUT = 1024,
  parameter int CNT_BITS     = $clog2(LINK_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            load_link_s3,
  input  logic            check_link_s3,
  input  logic            mem_rw_s3,
  input  logic [3:0]      byte_en_s3,
  input  logic [BITS-1:0] eff_addr,
  input  logic            halt_s3,
  input  logic            snoop_wr,
  input  logic [BITS-1:0] snoop_addr,
  output logic            sc_kill,
  output logic            sc_valid_s4,
  output logic            sc_pass_s4,
  output logic            link_valid,
  output logic [BITS-3:0] link_addr
);

  typedef enum logic [1:0] {S_IDLE, S_LINKED, S_HALTED} state_t;

  // Timer keeps at least one bit so a disabled timeout still elaborates.
  localparam int TW = (CNT_BITS > 0) ? CNT_BITS : 1;
  localparam logic [TW-1:0] TMAX = TW'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [BITS-3:0] link_addr_nx;
  logic            ll, sc, st, halt;
  logic            addr_match, snoop_match, expire, sc_pass, sc_res;

  assign ll          = ex_valid & ~load_link_s3;
  assign sc          = ex_valid & check_link_s3;
  assign st          = ex_valid & ~mem_rw_s3 & ~check_link_s3;
  assign halt        = ex_valid & halt_s3;
  assign addr_match  = (eff_addr[BITS-1:2] == link_addr);
  assign snoop_match = snoop_wr & (snoop_addr[BITS-1:2] == link_addr);
  assign expire      = (LINK_TIMEOUT != 0) && (timer == TMAX);
  assign sc_pass     = sc & (state == S_LINKED) & addr_match & (eff_addr[1:0] == 2'b00)
                     & (byte_en_s3 == 4'b1111) & ~snoop_match;
  assign link_valid  = (state == S_LINKED);

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    link_addr_nx = link_addr;
    sc_kill      = 1'b0;
    sc_res       = 1'b0;
    case (state)
      S_HALTED: ;
      default: begin
        if (halt) begin
          state_nx = S_HALTED;
          timer_nx = '0;
        end else if (sc) begin
          // SC consumes the reservation whether it passes or not.
          sc_kill  = ~sc_pass;
          sc_res   = 1'b1;
          state_nx = S_IDLE;
          timer_nx = '0;
        end else if (ll) begin
          state_nx     = S_LINKED;
          link_addr_nx = eff_addr[BITS-1:2];
          timer_nx     = '0;
        end else if (state == S_LINKED) begin
          if ((st & addr_match) | snoop_match | expire) begin
            state_nx = S_IDLE;
            timer_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      link_addr   <= '0;
      sc_valid_s4 <= 1'b0;
      sc_pass_s4  <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      link_addr   <= link_addr_nx;
      sc_valid_s4 <= sc_res;
      sc_pass_s4  <= sc_res & sc_pass;
    end
  end

endmodule

// File: tb/tb_ll_sc_link_unit.sv
// Bench for ll_sc_link_unit: directed scenarios plus randomized traffic
// checked against a reservation model kept in the bench.
module tb_ll_sc_link_unit;

  localparam int TO = 4;

  logic        clk, rst;
  logic        ex_valid, load_link_s3, check_link_s3, mem_rw_s3, halt_s3, snoop_wr;
  logic [3:0]  byte_en_s3;
  logic [31:0] eff_addr, snoop_addr;
  logic        sc_kill, sc_valid_s4, sc_pass_s4, link_valid;
  logic [29:0] link_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_linked, m_halted;
  logic [29:0] m_word;
  int          m_age;
  bit          m_sv, m_sp;

  ll_sc_link_unit #(.BITS(32), .LINK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .load_link_s3(load_link_s3),
    .check_link_s3(check_link_s3), .mem_rw_s3(mem_rw_s3), .byte_en_s3(byte_en_s3),
    .eff_addr(eff_addr), .halt_s3(halt_s3), .snoop_wr(snoop_wr), .snoop_addr(snoop_addr),
    .sc_kill(sc_kill), .sc_valid_s4(sc_valid_s4), .sc_pass_s4(sc_pass_s4),
    .link_valid(link_valid), .link_addr(link_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_linked = 0; m_halted = 0; m_word = '0; m_age = 0; m_sv = 0; m_sp = 0;
  endtask

  // One EX cycle: drive, check sc_kill, advance model, check registered outputs.
  task automatic step(input bit ev, input bit is_ll, input bit is_sc, input bit is_st,
                      input logic [3:0] be, input logic [31:0] addr, input bit hlt,
                      input bit snw, input logic [31:0] saddr);
    bit wmatch, smatch, pass, chk_kill, e_kill;
    ex_valid = ev; load_link_s3 = ~is_ll; check_link_s3 = is_sc;
    mem_rw_s3 = ~(is_st | is_sc); byte_en_s3 = be; eff_addr = addr;
    halt_s3 = hlt; snoop_wr = snw; snoop_addr = saddr;
    #2;
    wmatch = m_linked && (addr[31:2] == m_word);
    smatch = m_linked && snw && (saddr[31:2] == m_word);
    pass   = ev && is_sc && wmatch && (addr[1:0] == 2'b00) && (be == 4'hF) && !smatch;
    chk_kill = 0; e_kill = 0;
    if (m_halted) begin
      m_sv = 0; m_sp = 0;
    end else if (ev && hlt) begin
      m_halted = 1; m_linked = 0; m_sv = 0; m_sp = 0;
    end else begin
      chk_kill = 1;
      e_kill = ev && is_sc && !pass;
      m_sv = ev && is_sc;
      m_sp = pass;
      if (ev && is_sc) m_linked = 0;
      else if (ev && is_ll) begin
        m_linked = 1; m_word = addr[31:2]; m_age = 0;
      end else if (m_linked) begin
        if ((ev && is_st && wmatch) || smatch) m_linked = 0;
        else begin
          m_age++;
          if (m_age == TO) m_linked = 0;
        end
      end
    end
    if (chk_kill) check("sc_kill", 32'(sc_kill), 32'(e_kill));
    @(posedge clk); #1;
    check("link_valid", 32'(link_valid), 32'(m_linked));
    if (m_linked) check("link_addr", 32'(link_addr), 32'(m_word));
    check("sc_valid_s4", 32'(sc_valid_s4), 32'(m_sv));
    if (m_sv) check("sc_pass_s4", 32'(sc_pass_s4), 32'(m_sp));
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; load_link_s3 = 1; check_link_s3 = 0; mem_rw_s3 = 1;
    byte_en_s3 = 0; eff_addr = 0; halt_s3 = 0; snoop_wr = 0; snoop_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_link_valid", 32'(link_valid), 32'd0);
    check("rst_link_addr", 32'(link_addr), 32'd0);
    check("rst_sc_valid", 32'(sc_valid_s4), 32'd0);
    check("rst_sc_pass", 32'(sc_pass_s4), 32'd0);
    rst = 1'b0;
    ex_valid = 0; check_link_s3 = 1; #1;
    check("bubble_kill", 32'(sc_kill), 32'd0);

    // LL then SC same word: pass
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    check("sc_pass_basic", 32'(sc_pass_s4), 32'd1);
    // Store to linked word clears the reservation
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 0, 1, 4'h4, 32'h102, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    // Matching snoop during SC fails; neighbouring-word snoop does not
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 1, 32'h103);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 1, 32'h104);
    // Timeout: 4 idle cycles expire, 3 do not
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    repeat (4) nop();
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    repeat (3) nop();
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    // Back-to-back SCs, partial byte enables, misaligned SC, SC+LL together
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'h3, 32'h100, 0, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h101, 0, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 1, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    // LL with snoop to the new word: LL wins
    step(1, 1, 0, 0, 4'hF, 32'h200, 0, 1, 32'h200);
    step(1, 0, 1, 0, 4'hF, 32'h200, 0, 0, 0);

    // Halt is absorbing until reset
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 0, 0, 4'h0, 32'h0, 1, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    do_reset();
    check("post_halt_rst", 32'(link_valid), 32'd0);
    step(1, 1, 0, 0, 4'hF, 32'h300, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0);

    // Asynchronous reset mid-link, with an SC result pending
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    step(1, 1, 0, 0, 4'hF, 32'h100, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_link", 32'(link_valid), 32'd0);
    check("async_rst_scv", 32'(sc_valid_s4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      bit ev, l, s, t, sw;
      int op;
      logic [3:0] be;
      logic [31:0] a, sa;
      ev = ($urandom_range(0, 99) < 85);
      op = $urandom_range(0, 3);
      l  = (op == 0) || (op == 1 && $urandom_range(0, 7) == 0);
      s  = (op == 1);
      t  = (op == 2);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      a  = 32'h100 + 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      sw = ($urandom_range(0, 99) < 15);
      sa = 32'h100 + 32'($urandom_range(0, 11));
      step(ev, l, s, t, be, a, 0, sw, sa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ll_sc_link_unit.md
# ll_sc_link_unit

Load-link / store-conditional reservation monitor that consumes the ID/EX pipeline-register outputs in the EX stage. It tracks one word-granular reservation set by LL and clears it on conflicting stores, external snoop writes, timeout or halt. It resolves each SC in the same EX cycle: it kills the SC store when the SC fails, and registers the pass/fail result into the EX/MEM boundary for write-back to rt.

## Interface
- `BITS`, 32, datapath / address width
- `LINK_TIMEOUT`, 1024, cycles a reservation may live before auto-expiry; 0 disables expiry
- `CNT_BITS`, `$clog2(LINK_TIMEOUT+1)`, timer width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  EX holds a real instruction; 0 means bubble, and all other EX inputs are ignored
- `load_link_s3`  in  1  active-low; 0 means an LL is in EX
- `check_link_s3`  in  1  active-high; 1 means an SC is in EX
- `mem_rw_s3`  in  1  0 means a store is in EX, 1 means read/none
- `byte_en_s3`  in  4  byte lanes of the EX memory op
- `eff_addr`  in  BITS  effective byte address from the ALU
- `halt_s3`  in  1  halt has reached EX
- `snoop_wr`  in  1  another master writes memory this cycle
- `snoop_addr`  in  BITS  byte address of that write
- `sc_kill`  out  1  combinational; suppress the memory write of the SC in EX
- `sc_valid_s4`  out  1  registered; an SC result is present in MEM
- `sc_pass_s4`  out  1  registered; 1 means the SC succeeded (rt ← 1), 0 means it failed (rt ← 0)
- `link_valid`  out  1  reservation held (state LINKED)
- `link_addr`  out  BITS-2  reserved word address (`eff_addr[BITS-1:2]`)

## Operation
- Qualifiers: LL = `ex_valid & ~load_link_s3`; SC = `ex_valid & check_link_s3`; ST = `ex_valid & ~mem_rw_s3 & ~check_link_s3`; HALT = `ex_valid & halt_s3`.
- Word match is a comparison of `addr[BITS-1:2]` against `link_addr`.
- State machine has three states: IDLE, LINKED, HALTED.
- IDLE:
  - LL → LINKED; capture `link_addr`; clear timer.
  - SC → fail.
- LINKED:
  - LL → stay LINKED; recapture `link_addr`; clear timer.
  - SC → IDLE, pass or fail.
  - ST to matching word → IDLE.
  - `snoop_wr` to matching word → IDLE.
  - Timer expiry → IDLE.
  - Otherwise the timer increments.
- HALTED: absorbing state; all inputs ignored; exited only by `rst`.
- HALT from any state → HALTED; the reservation is cleared. HALT has priority over everything.
- SC passes iff all of the following hold:
  - state is LINKED;
  - word matches;
  - `eff_addr[1:0]==0`;
  - `byte_en_s3==4'b1111`;
  - no matching `snoop_wr` in the same cycle.
- `sc_kill` = SC & ~pass. It is combinational and valid in the same cycle.
- Priority of simultaneous events:
  - HALT > SC > LL > ST/snoop/timeout.
  - SC with LL both asserted: treated as SC only.
  - LL with a snoop in the same cycle: LL wins and the new link is established.
  - SC with a matching snoop in the same cycle: the SC fails.
  - ST to a non-matching word: no effect.
- Timer: counts cycles spent in LINKED. When the count equals `LINK_TIMEOUT-1` with no LL/SC that cycle, the next edge goes to IDLE. A new LL restarts the count from 0.

## Timing
- Reset values:
  - state IDLE
  - `link_valid`=0
  - `link_addr`=0
  - timer=0
  - `sc_valid_s4`=0
  - `sc_pass_s4`=0
  - `sc_kill`=0 whenever `ex_valid`=0
- `link_valid` rises one edge after the LL cycle and falls one edge after the clearing event.
- SC result: `sc_valid_s4`/`sc_pass_s4` update on the edge ending the SC cycle (latency 1). `sc_valid_s4` is a one-cycle pulse unless SCs are back-to-back.
- Back-to-back SCs: the second SC always fails, because the first SC cleared the reservation.
- Reset mid-operation: all state is cleared immediately (asynchronously); a pending SC result is lost.

## Test plan
- LL @0x100, then SC @0x100 with `byte_en`=F → `sc_kill`=0; next cycle `sc_valid_s4`=1, `sc_pass_s4`=1; `link_valid`=0.
- LL @0x100; store @0x102; SC @0x100 → reservation cleared by the store; `sc_kill`=1; `sc_pass_s4`=0.
- LL @0x100; SC @0x100 in the same cycle as `snoop_wr` @0x103 → `sc_kill`=1, `sc_pass_s4`=0. Separately, a snoop @0x104 leaves the link intact and the SC passes.
- `LINK_TIMEOUT`=4: LL, then 4 idle cycles, then SC → `link_valid` drops after the 4th LINKED cycle; SC fails. LL then SC after 3 idle cycles → passes.
- Halt: LL, HALT, then LL and SC → `link_valid` stays 0 and `sc_valid_s4` stays 0 (SC ignored) until `rst`. After `rst`, state is IDLE.
- SC with `byte_en`=4'b0011, or SC @0x101 while linked to 0x100 → fails. Asserting `rst` mid-link → `link_valid`=0 immediately.
